stk_rsp_q: RTL and testbench

STK_RSP_Q -- requirements
Module: stk_rsp_q

---
 rtl/cfg_pkg.sv | 7 +
 rtl/stk_pkg.sv | 10 +
 rtl/stk_rsp_fifo.sv | 82 ++++++++
 rtl/stk_rsp_q.sv | 58 +++++
 tb/tb_stk_rsp_q.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cfg_pkg.sv
// Project-wide configuration constants.
// Shared by the stack engines and their response queues.
package cfg_pkg;

  localparam int ENGS_N = 4;

endpackage

// File: rtl/stk_pkg.sv
// Stack-engine shared types and constants.
// Used by the response queue and its per-engine FIFO.
package stk_pkg;

  localparam int RSP_W       = 128;
  localparam int RSP_Q_DEPTH = 4;

  typedef logic [RSP_W-1:0] rsp_dat_t;

endpackage

// File: rtl/stk_rsp_fifo.sv
// Single-engine response FIFO with almost-full and sticky overflow.
// Head is read straight from storage; no push-to-head bypass.
module stk_rsp_fifo
  import stk_pkg::*;
#(
  parameter int DEPTH = RSP_Q_DEPTH
) (
  input  logic     clk,
  input  logic     arst_n,
  input  logic     push_i,
  input  rsp_dat_t dat_i,
  input  logic     rdy_i,
  output logic     vld_o,
  output rsp_dat_t dat_o,
  output logic     afull_o,
  output logic     ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(DEPTH - 1);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  rsp_dat_t      mem_q [DEPTH];

  logic full;
  logic pop;
  logic wr;

  always_comb begin
    vld_o  = (cnt_q != '0);
    full   = (cnt_q == FULL_C);
    pop    = vld_o & rdy_i;
    // A full queue still takes a push when the head leaves this edge.
    wr     = push_i & (~full | pop);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | (push_i & full & ~pop);
    if (wr) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({wr, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wptr_q] <= dat_i;
    end
  end

  assign dat_o   = mem_q[rptr_q];
  assign afull_o = (cnt_q >= AFULL_C);
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/stk_rsp_q.sv
// Per-engine response queues fed from one shared response bus.
// Rejects non-one-hot strobes and flags them with a sticky error.
module stk_rsp_q
  import stk_pkg::*;
#(
  parameter int DEPTH  = RSP_Q_DEPTH,
  parameter int ENGS_N = cfg_pkg::ENGS_N
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [ENGS_N-1:0]     i_rsp_vld,
  input  rsp_dat_t              i_rsp_dat,
  output logic [ENGS_N-1:0]     o_rsp_vld,
  output rsp_dat_t [ENGS_N-1:0] o_rsp_dat,
  input  logic [ENGS_N-1:0]     i_rsp_rdy,
  output logic [ENGS_N-1:0]     o_afull,
  output logic [ENGS_N-1:0]     o_ovf,
  output logic                  o_err
);

  logic              multi;
  logic [ENGS_N-1:0] push;
  logic              err_q, err_d;

  always_comb begin
    // x & (x-1) is non-zero exactly when two or more bits are set.
    multi = |(i_rsp_vld & (i_rsp_vld - ENGS_N'(1)));
    push  = multi ? '0 : i_rsp_vld;
    err_d = err_q | multi;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err = err_q;

  for (genvar e = 0; e < ENGS_N; e++) begin : g_eng
    stk_rsp_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk    (clk),
      .arst_n (arst_n),
      .push_i (push[e]),
      .dat_i  (i_rsp_dat),
      .rdy_i  (i_rsp_rdy[e]),
      .vld_o  (o_rsp_vld[e]),
      .dat_o  (o_rsp_dat[e]),
      .afull_o(o_afull[e]),
      .ovf_o  (o_ovf[e])
    );
  end

endmodule

// File: tb/tb_stk_rsp_q.sv
// Directed vector table plus reset and random scoreboard sequences
// for the per-engine response queue.
module tb_stk_rsp_q;
  import stk_pkg::*;

  localparam int EN = 4;
  localparam int DP = 4;

  logic                  clk;
  logic                  arst_n;
  logic [EN-1:0]         i_rsp_vld;
  rsp_dat_t              i_rsp_dat;
  logic [EN-1:0]         o_rsp_vld;
  rsp_dat_t [EN-1:0]     o_rsp_dat;
  logic [EN-1:0]         i_rsp_rdy;
  logic [EN-1:0]         o_afull;
  logic [EN-1:0]         o_ovf;
  logic                  o_err;

  stk_rsp_q #(
    .DEPTH (DP),
    .ENGS_N(EN)
  ) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .i_rsp_vld(i_rsp_vld),
    .i_rsp_dat(i_rsp_dat),
    .o_rsp_vld(o_rsp_vld),
    .o_rsp_dat(o_rsp_dat),
    .i_rsp_rdy(i_rsp_rdy),
    .o_afull  (o_afull),
    .o_ovf    (o_ovf),
    .o_err    (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [EN-1:0] vld;
    logic [EN-1:0] rdy;
    logic [7:0]    dat;
    logic [EN-1:0] e_vld;
    logic [EN-1:0] e_afull;
    logic [EN-1:0] e_ovf;
    logic          e_err;
    int            sel;
    logic [7:0]    e_dat;
  } vec_t;

  vec_t vecs[$];
  int   n_run;
  int   n_fail;
  rsp_dat_t sb [EN][$];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [EN-1:0] v, input logic [EN-1:0] r,
                     input logic [7:0] d, input logic [EN-1:0] ev,
                     input logic [EN-1:0] ea, input logic [EN-1:0] eo,
                     input logic ee, input int s, input logic [7:0] ed);
    vec_t t;
    t.vld = v; t.rdy = r; t.dat = d;
    t.e_vld = ev; t.e_afull = ea; t.e_ovf = eo;
    t.e_err = ee; t.sel = s; t.e_dat = ed;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic [EN-1:0] v, input logic [EN-1:0] r,
                       input rsp_dat_t d);
    i_rsp_vld = v;
    i_rsp_rdy = r;
    i_rsp_dat = d;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    drive('0, '0, '0);
    arst_n = 1'b0;

    // vld rdy dat | e_vld e_afull e_ovf e_err sel e_dat
    add(4'b0100, 4'b0100, 8'hA5, 4'b0100, 4'b0000, 4'b0000, 0, 2, 8'hA5);
    add(4'b0000, 4'b0100, 8'h00, 4'b0000, 4'b0000, 4'b0000, 0, 2, 8'h00);
    add(4'b0001, 4'b0000, 8'h01, 4'b0001, 4'b0000, 4'b0000, 0, 0, 8'h01);
    add(4'b0001, 4'b0000, 8'h02, 4'b0001, 4'b0000, 4'b0000, 0, 0, 8'h01);
    add(4'b0001, 4'b0000, 8'h03, 4'b0001, 4'b0001, 4'b0000, 0, 0, 8'h01);
    add(4'b0001, 4'b0000, 8'h04, 4'b0001, 4'b0001, 4'b0000, 0, 0, 8'h01);
    add(4'b0001, 4'b0000, 8'h05, 4'b0001, 4'b0001, 4'b0001, 0, 0, 8'h01);
    add(4'b0000, 4'b0001, 8'h00, 4'b0001, 4'b0001, 4'b0001, 0, 0, 8'h02);
    add(4'b0000, 4'b0001, 8'h00, 4'b0001, 4'b0000, 4'b0001, 0, 0, 8'h03);
    add(4'b0000, 4'b0001, 8'h00, 4'b0001, 4'b0000, 4'b0001, 0, 0, 8'h04);
    add(4'b0000, 4'b0001, 8'h00, 4'b0000, 4'b0000, 4'b0001, 0, 0, 8'h00);
    add(4'b0010, 4'b0000, 8'h11, 4'b0010, 4'b0000, 4'b0001, 0, 1, 8'h11);
    add(4'b0010, 4'b0000, 8'h12, 4'b0010, 4'b0000, 4'b0001, 0, 1, 8'h11);
    add(4'b0010, 4'b0000, 8'h13, 4'b0010, 4'b0010, 4'b0001, 0, 1, 8'h11);
    add(4'b0010, 4'b0000, 8'h14, 4'b0010, 4'b0010, 4'b0001, 0, 1, 8'h11);
    add(4'b0010, 4'b0010, 8'h07, 4'b0010, 4'b0010, 4'b0001, 0, 1, 8'h12);
    add(4'b0000, 4'b0010, 8'h00, 4'b0010, 4'b0010, 4'b0001, 0, 1, 8'h13);
    add(4'b0000, 4'b0010, 8'h00, 4'b0010, 4'b0000, 4'b0001, 0, 1, 8'h14);
    add(4'b0000, 4'b0010, 8'h00, 4'b0010, 4'b0000, 4'b0001, 0, 1, 8'h07);
    add(4'b0000, 4'b0010, 8'h00, 4'b0000, 4'b0000, 4'b0001, 0, 1, 8'h00);
    add(4'b0011, 4'b0000, 8'h09, 4'b0000, 4'b0000, 4'b0001, 1, 0, 8'h00);
    add(4'b0000, 4'b1111, 8'h00, 4'b0000, 4'b0000, 4'b0001, 1, 0, 8'h00);

    #12;
    chk("rst_vld", 128'(o_rsp_vld), 128'(0));
    chk("rst_afull", 128'(o_afull), 128'(0));
    chk("rst_ovf", 128'(o_ovf), 128'(0));
    chk("rst_err", 128'(o_err), 128'(0));
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].vld, vecs[i].rdy, 128'(vecs[i].dat));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_vld", i), 128'(o_rsp_vld), 128'(vecs[i].e_vld));
      chk($sformatf("v%0d_afull", i), 128'(o_afull),
          128'(vecs[i].e_afull));
      chk($sformatf("v%0d_ovf", i), 128'(o_ovf), 128'(vecs[i].e_ovf));
      chk($sformatf("v%0d_err", i), 128'(o_err), 128'(vecs[i].e_err));
      if (vecs[i].e_vld[vecs[i].sel]) begin
        chk($sformatf("v%0d_dat", i), o_rsp_dat[vecs[i].sel],
            128'(vecs[i].e_dat));
      end
    end

    // Mid-cycle reset drops queued words; first push after is the head.
    @(negedge clk);
    arst_n = 1'b0;
    drive('0, '0, '0);
    @(negedge clk);
    arst_n = 1'b1;
    drive(4'b1000, 4'b0000, 128'h21);
    @(negedge clk);
    drive(4'b1000, 4'b0000, 128'h22);
    @(negedge clk);
    drive('0, '0, '0);
    chk("rs_fill_vld", 128'(o_rsp_vld), 128'(4'b1000));
    @(posedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    chk("rs_async_vld", 128'(o_rsp_vld), 128'(0));
    chk("rs_async_err", 128'(o_err), 128'(0));
    chk("rs_async_ovf", 128'(o_ovf), 128'(0));
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("rs_empty_vld", 128'(o_rsp_vld), 128'(0));
    drive(4'b1000, 4'b0000, 128'hB);
    @(negedge clk);
    drive('0, 4'b1000, '0);
    chk("rs_first_vld", 128'(o_rsp_vld), 128'(4'b1000));
    chk("rs_first_dat", o_rsp_dat[3], 128'hB);
    @(negedge clk);
    drive('0, '0, '0);
    chk("rs_drained", 128'(o_rsp_vld), 128'(0));

    // Random one-hot pushes gated by afull, random ready.
    for (int c = 0; c < 3000; c++) begin
      logic [EN-1:0] rdy;
      logic [EN-1:0] vld;
      rsp_dat_t      d;
      int            e;
      @(negedge clk);
      rdy = EN'($urandom_range(0, (1 << EN) - 1));
      for (int k = 0; k < EN; k++) begin
        chk($sformatf("rnd_vld%0d", k), 128'(o_rsp_vld[k]),
            128'(sb[k].size() != 0));
        if (o_rsp_vld[k] && rdy[k] && sb[k].size() != 0) begin
          chk($sformatf("rnd_dat%0d", k), o_rsp_dat[k], sb[k][0]);
          void'(sb[k].pop_front());
        end
      end
      e = $urandom_range(0, EN - 1);
      d = {$urandom, $urandom, $urandom, $urandom};
      vld = '0;
      if ($urandom_range(0, 3) != 0 && !o_afull[e]) begin
        vld[e] = 1'b1;
        sb[e].push_back(d);
      end
      drive(vld, rdy, d);
    end
    @(negedge clk);
    drive('0, '0, '0);
    chk("rnd_ovf", 128'(o_ovf), 128'(0));
    chk("rnd_err", 128'(o_err), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
